// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: default width, FSM state
// encodings and the bit-counter width helper.
package serial_sub_pkg;

    localparam int SUB_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One extra bit so the counter can represent WIDTH itself
    function automatic int calc_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = calc_cnt_w(SUB_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the stage borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_eight_bit_subtractor.sv
// Bit-serial subtractor, diff = A - B - Bin, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_eight_bit_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CW       = calc_cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             fs_d, fs_bout;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign res_next = {fs_d, res_q[WIDTH-1:1]};

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, serial shift, and result copy on entry to DONE
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    bor_d   = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SHIFT: begin
                res_d  = res_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bor_d  = fs_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d   = res_next;
                    borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    diff_d = diff_q;
                end
            end
            ST_DONE: cnt_d = cnt_q;
            default: cnt_d = '0;
        endcase
    end

    // Handshake outputs decoded from the next state so they are registered
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_eight_bit_subtractor.sv
// Scoreboard bench for serial_eight_bit_subtractor: directed vectors push
// expected results, a negedge monitor pops and compares on every done.
module tb_serial_eight_bit_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         bin_in = 1'b0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic [W-1:0] prev_diff = '0;
    logic         prev_borrow = 1'b0;
    logic         done_prev = 1'b0;

    serial_eight_bit_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .Bin    (bin_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                check("done_single_cycle", {31'd0, done_prev}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("diff", {24'd0, diff}, {24'd0, e.diff});
                    check("borrow", {31'd0, borrow}, {31'd0, e.borrow});
`ifdef SERIAL_SUB_OVERFLOW_EN
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
                end
            end
            done_prev <= done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    // Issue one operation and wait for its done; optionally poke start mid-SHIFT
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input bit inject);
        int  busy_cnt = 0;
        bit  seen = 0;
        exp_t e;
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bi; start = 1'b1;
        e.diff = ed; e.borrow = eb; e.ovf = eo;
        sb_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                check("diff_hold", {24'd0, diff}, {24'd0, prev_diff});
                check("borrow_hold", {31'd0, borrow}, {31'd0, prev_borrow});
                if (inject && busy_cnt == 3) begin
                    a_in = 8'd200; b_in = 8'd100; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", busy_cnt, W);
        @(negedge clk);
        check("done_low_after", {31'd0, done}, 32'd0);
        prev_diff = ed;
        prev_borrow = eb;
    endtask

    initial begin
        int bc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_diff", {24'd0, diff}, 32'd0);
            check("idle_borrow", {31'd0, borrow}, 32'd0);
        end

        run_op(8'd91, 8'd43, 1'b0, 8'd48, 1'b0, 1'b0, 0);
        run_op(8'd43, 8'd91, 1'b0, 8'd208, 1'b1, 1'b0, 0);
        run_op(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0, 0);
        run_op(8'd99, 8'd12, 1'b1, 8'd86, 1'b0, 1'b0, 0);
        run_op(8'd55, 8'd1, 1'b0, 8'd54, 1'b0, 1'b0, 1);
        repeat (15) @(negedge clk);
        check("no_extra_op", sb_q.size(), 0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        a_in = 8'd16; b_in = 8'd22; bin_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bc = 0;
        for (int i = 0; i < 20 && bc < 4; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_diff = '0;
        prev_borrow = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_no_done_diff", {24'd0, diff}, 32'd0);
        check("rst_no_done_busy", {31'd0, busy}, 32'd0);
        run_op(8'd16, 8'd22, 1'b1, 8'd249, 1'b1, 1'b0, 0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op(8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1, 0);
        run_op(8'd91, 8'd43, 1'b0, 8'd48, 1'b0, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
